keypad_scan_queue: RTL and testbench

- Parametrised successor to the team's 4x4 keypad scanner.
- Drives an ROWS x COLS matrix one row at a time and debounces a per-frame key snapshot.
- Detects press events and queues their key codes in a FIFO with a valid/ready handshake.
- Sits between the keypad pins and consumers such as the dot-matrix or 7-segment controllers, replacing the single overwrite-on-press buffer.

---
 rtl/keypad_scan_queue.sv | 220 ++++++++++++++++++++++
 tb/tb_keypad_scan_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_queue.sv
// Row-scanned keypad with per-frame debounce and a press-event FIFO (valid/ready).
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_queue #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 250000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 8,
`ifdef KEYPAD_REPEAT_EN
  parameter int REPEAT_FRAMES = 40,
`endif
  localparam int CW = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] keypadCol,
  output logic [ROWS-1:0] keypadRow,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  input  logic            key_ready,
  output logic            key_held,
  output logic [CW-1:0]   held_code,
  output logic            multi_key,
  output logic            overflow,
  input  logic            ovf_clear
);

  // state    | meaning
  // STABLE   | stable class S accepted, watching for a differing frame
  // CHECK    | candidate C seen for N consecutive frames, not yet accepted
  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int NW = $clog2(DEBOUNCE+1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] K_NONE = 2'd0, K_ONE = 2'd1, K_MULTI = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [CW-1:0] code;
  } cls_t;

  typedef enum logic {ST_STABLE, ST_CHECK} state_t;

  logic [DW-1:0] dwell;
  logic [RW-1:0] row_idx;
  logic [1:0]    acc_cnt;
  logic [CW-1:0] acc_code;
  logic          sample, frame_close;
  logic [1:0]    row_cnt, merged_cnt;
  logic [2:0]    cnt_sum;
  logic [CW-1:0] row_code, merged_code;
  cls_t          frame_cls;

  assign sample      = (dwell == DW'(SCAN_DIV-1));
  assign frame_close = sample && (row_idx == RW'(ROWS-1));
  assign keypadRow   = ~(ROWS'(1) << row_idx);

  // Low-bit count saturates at 2; code is only meaningful when the frame total is 1.
  always_comb begin
    row_cnt  = 2'd0;
    row_code = '0;
    for (int c = COLS-1; c >= 0; c--) begin
      if (!keypadCol[c]) begin
        row_code = CW'(int'(row_idx)*COLS + c);
        if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
      end
    end
    cnt_sum        = {1'b0, acc_cnt} + {1'b0, row_cnt};
    merged_cnt     = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
    merged_code    = (acc_cnt == 2'd0) ? row_code : acc_code;
    frame_cls.kind = (merged_cnt == 2'd0) ? K_NONE : (merged_cnt == 2'd1) ? K_ONE : K_MULTI;
    frame_cls.code = (merged_cnt == 2'd1) ? merged_code : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell    <= '0;
      row_idx  <= '0;
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (sample) begin
      dwell <= '0;
      if (frame_close) begin
        row_idx  <= '0;
        acc_cnt  <= '0;
        acc_code <= '0;
      end else begin
        row_idx  <= row_idx + 1'b1;
        acc_cnt  <= merged_cnt;
        acc_code <= merged_code;
      end
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  state_t        state, state_nx;
  cls_t          s_cls, s_nx, c_cls, c_nx;
  logic [NW-1:0] n_cnt, n_nx;
  logic          press_evt, rpt_evt, evt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_STABLE;
      s_cls <= '0;
      c_cls <= '0;
      n_cnt <= '0;
    end else begin
      state <= state_nx;
      s_cls <= s_nx;
      c_cls <= c_nx;
      n_cnt <= n_nx;
    end
  end

  always_comb begin
    state_nx = state;
    s_nx     = s_cls;
    c_nx     = c_cls;
    n_nx     = n_cnt;
    if (frame_close) begin
      case (state)
        ST_STABLE: begin
          if (frame_cls != s_cls) begin
            if (DEBOUNCE == 1) begin
              s_nx = frame_cls;
            end else begin
              state_nx = ST_CHECK;
              c_nx     = frame_cls;
              n_nx     = NW'(1);
            end
          end
        end
        ST_CHECK: begin
          if (frame_cls == s_cls) begin
            state_nx = ST_STABLE;
          end else if (frame_cls != c_cls) begin
            c_nx = frame_cls;
            n_nx = NW'(1);
          end else if (int'(n_cnt) + 1 >= DEBOUNCE) begin
            s_nx     = c_cls;
            state_nx = ST_STABLE;
          end else begin
            n_nx = n_cnt + 1'b1;
          end
        end
        default: state_nx = ST_STABLE;
      endcase
    end
    press_evt = (s_nx != s_cls) && (s_nx.kind == K_ONE);
    evt       = press_evt || rpt_evt;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int PW = $clog2(REPEAT_FRAMES+1);
  logic [PW-1:0] rpt_cnt;
  logic          rpt_tick;

  assign rpt_tick = frame_close && (s_cls.kind == K_ONE) && (s_nx == s_cls);
  assign rpt_evt  = rpt_tick && (rpt_cnt == PW'(REPEAT_FRAMES-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                rpt_cnt <= '0;
    else if (s_nx != s_cls)  rpt_cnt <= '0;
    else if (rpt_tick)       rpt_cnt <= rpt_evt ? '0 : rpt_cnt + 1'b1;
  end
`else
  assign rpt_evt = 1'b0;
`endif

  assign key_held  = (s_cls.kind == K_ONE);
  assign held_code = s_cls.code;
  assign multi_key = (s_cls.kind == K_MULTI);

  // Event is registered once so the push lands on the cycle after the frame close.
  logic          push_pend;
  logic [CW-1:0] push_code;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_pend <= 1'b0;
      push_code <= '0;
    end else begin
      push_pend <= evt;
      push_code <= s_nx.code;
    end
  end

  logic [CW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, do_pop, do_push, drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign do_pop  = !empty && key_ready;
  assign do_push = push_pend && (!full || do_pop);
  assign drop    = push_pend && full && !do_pop;

  assign key_valid = !empty;
  assign key_code  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)        wr_ptr   <= wr_ptr + 1'b1;
      if (do_pop)         rd_ptr   <= rd_ptr + 1'b1;
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_queue.sv
// Directed bench for keypad_scan_queue: 4x4 matrix, SCAN_DIV=4, DEBOUNCE=3, FIFO_DEPTH=8.
module tb_keypad_scan_queue;

  logic        clk, rst;
  logic [3:0]  keypadCol, keypadRow;
  logic        key_valid, key_ready, key_held, multi_key, overflow, ovf_clear;
  logic [3:0]  key_code, held_code;
  logic [15:0] keys;
  int          total, bad, cyc;

  keypad_scan_queue #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .keypadCol(keypadCol), .keypadRow(keypadRow),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .key_held(key_held), .held_code(held_code), .multi_key(multi_key),
    .overflow(overflow), .ovf_clear(ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    keypadCol = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!keypadRow[r] && keys[r*4+c]) keypadCol[c] = 1'b0;
  end

  typedef struct {
    int          cyc;
    logic [15:0] keys;
    logic [3:0]  row;
    logic        valid;
    logic [3:0]  code;
    logic        held;
    logic [3:0]  hcode;
    logic        multi;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  // Hold one key for three full frames; returns on the push cycle of its event.
  task automatic press(input int k);
    wait_to(((cyc + 15) / 16) * 16);
    keys = 16'h0001 << k;
    wait_to(cyc + 48);
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int   exp5 [8];
    int   exp6 [8];
    logic saw_valid, saw_held;
    total = 0; bad = 0; cyc = 0;
    keys = '0; key_ready = 1'b0; ovf_clear = 1'b0; rst = 1'b0;

    tbl[0]  = '{0,   16'h0000, 4'b1110, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{3,   16'h0000, 4'b1110, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{4,   16'h0000, 4'b1101, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{8,   16'h0000, 4'b1011, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl[4]  = '{12,  16'h0000, 4'b0111, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl[5]  = '{15,  16'h0000, 4'b0111, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl[6]  = '{16,  16'h0000, 4'b1110, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl[7]  = '{32,  16'h0200, 4'b1110, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl[8]  = '{79,  16'h0200, 4'b0111, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl[9]  = '{80,  16'h0200, 4'b1110, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0};
    tbl[10] = '{81,  16'h0200, 4'b1110, 1'b1, 4'd9, 1'b1, 4'd9, 1'b0};
    tbl[11] = '{112, 16'h0000, 4'b1110, 1'b1, 4'd9, 1'b1, 4'd9, 1'b0};
    tbl[12] = '{159, 16'h0000, 4'b0111, 1'b1, 4'd9, 1'b1, 4'd9, 1'b0};
    tbl[13] = '{160, 16'h0000, 4'b1110, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0};

    #2;
    chk("rst_row", int'(keypadRow), 4'b1110);
    chk("rst_valid", int'(key_valid), 0);
    release_reset();

    // Scan sequence and a clean press/release of code 9
    for (int i = 0; i < 14; i++) begin
      wait_to(tbl[i].cyc);
      keys = tbl[i].keys;
      chk($sformatf("vec%0d_row", i), int'(keypadRow), int'(tbl[i].row));
      chk($sformatf("vec%0d_valid", i), int'(key_valid), int'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("vec%0d_code", i), int'(key_code), int'(tbl[i].code));
      chk($sformatf("vec%0d_held", i), int'(key_held), int'(tbl[i].held));
      chk($sformatf("vec%0d_hcode", i), int'(held_code), int'(tbl[i].hcode));
      chk($sformatf("vec%0d_multi", i), int'(multi_key), int'(tbl[i].multi));
    end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("single_event_drained", int'(key_valid), 0);

    // Two-frame bounce must not be accepted
    wait_to(176);
    keys = 16'h0200; key_ready = 1'b1;
    saw_valid = 1'b0; saw_held = 1'b0;
    while (cyc < 239) begin
      if (cyc == 208) keys = '0;
      tick();
      saw_valid |= key_valid;
      saw_held  |= key_held;
    end
    key_ready = 1'b0;
    chk("bounce_no_event", int'(saw_valid), 0);
    chk("bounce_no_held", int'(saw_held), 0);

    // Two keys: MULTI without event, then single key 0 yields one event
    wait_to(240);
    keys = 16'h0081;
    wait_to(288);
    chk("multi_set", int'(multi_key), 1);
    chk("multi_held", int'(key_held), 0);
    wait_to(303);
    chk("multi_no_event", int'(key_valid), 0);
    wait_to(304);
    keys = 16'h0001;
    wait_to(352);
    chk("after_multi_multi", int'(multi_key), 0);
    chk("after_multi_held", int'(key_held), 1);
    chk("after_multi_hcode", int'(held_code), 0);
    chk("after_multi_valid_early", int'(key_valid), 0);
    tick();
    chk("after_multi_valid", int'(key_valid), 1);
    chk("after_multi_code", int'(key_code), 0);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    keys = '0;
    chk("after_multi_drained", int'(key_valid), 0);

    // Nine presses into an 8-deep FIFO with no consumer
    for (int k = 1; k <= 9; k++) press(k);
    chk("ovf_before_drop", int'(overflow), 0);
    tick();
    keys = '0;
    chk("ovf_after_drop", int'(overflow), 1);
    key_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp5[i] = i + 1;
      chk($sformatf("drain1_valid%0d", i), int'(key_valid), 1);
      chk($sformatf("drain1_code%0d", i), int'(key_code), exp5[i]);
      tick();
    end
    key_ready = 1'b0;
    chk("drain1_empty", int'(key_valid), 0);
    chk("ovf_sticky", int'(overflow), 1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // Fill, then push and pop together while full
    exp6 = '{12, 13, 14, 15, 0, 2, 4, 3};
    press(11); press(12); press(13); press(14);
    press(15); press(0);  press(2);  press(4);
    press(3);
    chk("full_valid", int'(key_valid), 1);
    chk("full_head", int'(key_code), 11);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    keys = '0;
    chk("pushpop_no_ovf", int'(overflow), 0);
    key_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain2_valid%0d", i), int'(key_valid), 1);
      chk($sformatf("drain2_code%0d", i), int'(key_code), exp6[i]);
      tick();
    end
    key_ready = 1'b0;
    chk("drain2_empty", int'(key_valid), 0);
    chk("drain2_ovf", int'(overflow), 0);

    // Reset mid-dwell with three queued events
    press(4); press(5); press(6);
    tick();
    chk("pre_rst_valid", int'(key_valid), 1);
    chk("pre_rst_head", int'(key_code), 4);
    wait_to(((cyc + 15) / 16) * 16 + 6);
    rst = 1'b0;
    #1;
    chk("mid_rst_row", int'(keypadRow), 4'b1110);
    chk("mid_rst_valid", int'(key_valid), 0);
    chk("mid_rst_code", int'(key_code), 0);
    chk("mid_rst_held", int'(key_held), 0);
    chk("mid_rst_hcode", int'(held_code), 0);
    chk("mid_rst_multi", int'(multi_key), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    keys = '0;
    release_reset();
    chk("restart_row0", int'(keypadRow), 4'b1110);
    wait_to(3);
    chk("restart_row3", int'(keypadRow), 4'b1110);
    wait_to(4);
    chk("restart_row4", int'(keypadRow), 4'b1101);
    wait_to(20);
    chk("restart_valid", int'(key_valid), 0);
    chk("restart_held", int'(key_held), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
